ir_cmd_conditioner: RTL
=======================

Name: ir_cmd_conditioner

Overview:
- Sits between the IR receiver (32-bit decoded frame plus data-ready) and the game processor inputs (left/right/stop/shoot/start).
- Replaces the current purely combinational key decode with a registered, validated command stage.
- Direction is held as a level; shoot/start are stretched to span at least one full processor_clock period, then followed by a repeat-suppression cooldown.
- Runs entirely on master_clk (50 MHz).

Parameters:
- HOLD_CYCLES, 240000: master_clk cycles that shoot/start stay high; must be ≥ one processor_clock period (237034).
- COOLDOWN_CYCLES, 2500000: cycles after a hold during which new shoot/start frames are dropped (50 ms).
- CNT_W, 22: timer width; must hold max(HOLD_CYCLES, COOLDOWN_CYCLES).
- CHECK_INV, 1: when 1, a frame is valid only if ir_data[31:24] == ~ir_data[23:16].

Ports:
- master_clk  in  1  50 MHz system clock
- resetn  in  1  asynchronous active-low reset
- data_ready  in  1  IR receiver frame-ready; level or pulse, only the rising edge counts
- ir_data  in  32  decoded IR frame; key code is ir_data[19:16]
- left  out  1  direction level, key 4
- right  out  1  direction level, key 6
- stop  out  1  direction level, keys 2/5/8
- shoot  out  1  stretched action pulse, key 5
- start  out  1  stretched action pulse, key 8
- cmd_valid  out  1  one-cycle strobe per accepted frame
- last_code  out  4  code of last accepted frame
- reject_count  out  8  saturating count of invalid frames

Behaviour:
- Reset (async, resetn=0): {stop,right,left}=100, shoot=0, start=0, cmd_valid=0, last_code=0, reject_count=0, FSM=IDLE, timer=0, edge register=0.
- Edge detect: data_ready is registered once; rdy_rise = data_ready & ~data_ready_q. Held-high data_ready yields exactly one event.
- Frame check on rdy_rise:
  - CHECK_INV=1 and inversion mismatch -> reject; reject_count increments, saturating at 255; no other output changes.
  - Codes other than 2/4/5/6/8 -> ignored; not counted, no cmd_valid.
- Accepted frame: cmd_valid=1 on the cycle after rdy_rise; last_code and direction update on that same cycle.
- Direction updates regardless of FSM state and stays one-hot:
  - 4 -> 001
  - 6 -> 010
  - 2, 5, 8 -> 100
- Action FSM, IDLE / HOLD / COOLDOWN:
  - IDLE + accepted 5 -> HOLD. shoot=1 on the same cycle as cmd_valid; timer loads HOLD_CYCLES-1.
  - IDLE + accepted 8 -> HOLD with start=1 instead; same timing.
  - HOLD: timer decrements each cycle. At 0 -> COOLDOWN with shoot=start=0; timer loads COOLDOWN_CYCLES-1. Net: the action output is high for exactly HOLD_CYCLES cycles.
  - COOLDOWN: timer decrements. At 0 -> IDLE.
  - Key 5/8 in HOLD or COOLDOWN: the direction part (100) applies and cmd_valid fires, but the action is dropped. No extension, no restart, and shoot/start are never both high.
- Reset mid-HOLD: outputs return to reset values immediately; no residual pulse after release.
- Timer arithmetic is unsigned CNT_W bits; it never wraps below 0, because the state changes at 0.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package ir_cmd_pkg:
  - key code constants KEY_STOP=4'h2, KEY_LEFT=4'h4, KEY_SHOOT=4'h5, KEY_RIGHT=4'h6, KEY_START=4'h8
  - direction encodings DIR_LEFT=3'b001, DIR_RIGHT=3'b010, DIR_STOP=3'b100
  - FSM state enum
- One sub-module: action_timer — loadable down-counter with a zero flag, instanced once and shared by HOLD and COOLDOWN.

Test Plan (HOLD_CYCLES=8, COOLDOWN_CYCLES=4, CHECK_INV=1):
- Reset release, no frames -> {stop,right,left}=100, shoot=start=0, reject_count=0.
- Valid frame, code 4, data_ready held high 20 cycles -> one cmd_valid, left=1 from cycle after the edge, last_code=4.
- Valid code 5 -> shoot high exactly 8 cycles, stop=1; a second code-5 frame 3 cycles later -> cmd_valid=1, shoot not extended (falls at cycle 8).
- Code 8 sent at hold cycle 8+2 (in COOLDOWN) -> start stays 0; the same code sent at cycle 8+4+1 -> start high 8 cycles.
- Frame with ir_data[31:24] = ir_data[23:16] (mismatch), repeated 300 times -> no cmd_valid, reject_count=255 (saturated).
- resetn asserted at shoot cycle 3 -> shoot=0 immediately; after release it stays 0 and FSM=IDLE.

Source files
------------

// File: rtl/ir_cmd_pkg.sv
// Shared key codes, direction encodings and action FSM states for the IR
// command conditioner.
package ir_cmd_pkg;

  localparam logic [3:0] KEY_STOP  = 4'h2;
  localparam logic [3:0] KEY_LEFT  = 4'h4;
  localparam logic [3:0] KEY_SHOOT = 4'h5;
  localparam logic [3:0] KEY_RIGHT = 4'h6;
  localparam logic [3:0] KEY_START = 4'h8;

  localparam logic [2:0] DIR_LEFT  = 3'b001;
  localparam logic [2:0] DIR_RIGHT = 3'b010;
  localparam logic [2:0] DIR_STOP  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_COOLDOWN = 2'd2
  } actState_t;

  function automatic logic isKnownKey(input logic [3:0] code);
    return (code == KEY_STOP) || (code == KEY_LEFT) || (code == KEY_SHOOT) ||
           (code == KEY_RIGHT) || (code == KEY_START);
  endfunction

  // Shoot and start keys also park the direction in the stop position.
  function automatic logic [2:0] keyToDir(input logic [3:0] code);
    if (code == KEY_LEFT)  return DIR_LEFT;
    if (code == KEY_RIGHT) return DIR_RIGHT;
    return DIR_STOP;
  endfunction

endpackage

// File: rtl/action_timer.sv
// Loadable down-counter with a zero flag; shared by the HOLD and COOLDOWN
// phases of the action FSM.
module action_timer #(
  parameter int unsigned CNT_W = 22
) (
  input  logic             master_clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Stops at zero so a stray decrement can never wrap the count.
  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ir_cmd_conditioner.sv
// Registered, validated command stage between the IR receiver and the game
// processor: direction levels plus stretched, cooldown-guarded action pulses.
module ir_cmd_conditioner
  import ir_cmd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 240000,
  parameter int unsigned COOLDOWN_CYCLES = 2500000,
  parameter int unsigned CNT_W           = 22,
  parameter bit          CHECK_INV       = 1'b1
) (
  input  logic        master_clk,
  input  logic        resetn,
  input  logic        data_ready,
  input  logic [31:0] ir_data,
  output logic        left,
  output logic        right,
  output logic        stop,
  output logic        shoot,
  output logic        start,
  output logic        cmd_valid,
  output logic [3:0]  last_code,
  output logic [7:0]  reject_count
);

  logic             dataReadyQ;
  logic             rdyRise;
  logic [3:0]       keyCode;
  logic [7:0]       invByte;
  logic             invOk;
  logic             frameAccept;
  logic             frameReject;
  logic             actionKey;
  logic [2:0]       dirReg;
  logic             cmdValidReg;
  logic [3:0]       lastCodeReg;
  logic [7:0]       rejectCountReg;
  actState_t        state;
  actState_t        stateNext;
  logic             shootReg;
  logic             shootNext;
  logic             startReg;
  logic             startNext;
  logic             timerLoad;
  logic             timerDec;
  logic             timerZero;
  logic [CNT_W-1:0] timerLoadValue;
  logic             unusedBits;

  assign rdyRise     = data_ready & ~dataReadyQ;
  assign keyCode     = ir_data[19:16];
  assign invByte     = ~ir_data[23:16];
  assign invOk       = !CHECK_INV || (ir_data[31:24] == invByte);
  assign frameReject = rdyRise & ~invOk;
  assign frameAccept = rdyRise & invOk & isKnownKey(keyCode);
  assign actionKey   = (keyCode == KEY_SHOOT) || (keyCode == KEY_START);
  assign unusedBits  = ^ir_data[15:0];

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      dataReadyQ     <= 1'b0;
      dirReg         <= DIR_STOP;
      cmdValidReg    <= 1'b0;
      lastCodeReg    <= 4'h0;
      rejectCountReg <= 8'h00;
    end else begin
      dataReadyQ  <= data_ready;
      cmdValidReg <= frameAccept;
      if (frameAccept) begin
        dirReg      <= keyToDir(keyCode);
        lastCodeReg <= keyCode;
      end
      if (frameReject && (rejectCountReg != 8'hFF)) begin
        rejectCountReg <= rejectCountReg + 8'h01;
      end
    end
  end

  // Action FSM: actions are only taken from IDLE, so repeats during HOLD or
  // COOLDOWN neither extend nor restart the pulse.
  always_comb begin
    stateNext      = state;
    shootNext      = shootReg;
    startNext      = startReg;
    timerLoad      = 1'b0;
    timerLoadValue = '0;
    timerDec       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (frameAccept && actionKey) begin
          stateNext      = ST_HOLD;
          timerLoad      = 1'b1;
          timerLoadValue = CNT_W'(HOLD_CYCLES - 1);
          shootNext      = (keyCode == KEY_SHOOT);
          startNext      = (keyCode == KEY_START);
        end
      end
      ST_HOLD: begin
        if (timerZero) begin
          stateNext      = ST_COOLDOWN;
          timerLoad      = 1'b1;
          timerLoadValue = CNT_W'(COOLDOWN_CYCLES - 1);
          shootNext      = 1'b0;
          startNext      = 1'b0;
        end else begin
          timerDec = 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (timerZero) stateNext = ST_IDLE;
        else           timerDec  = 1'b1;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      shootReg <= 1'b0;
      startReg <= 1'b0;
    end else begin
      state    <= stateNext;
      shootReg <= shootNext;
      startReg <= startNext;
    end
  end

  action_timer #(
    .CNT_W(CNT_W)
  ) actionTimer (
    .master_clk(master_clk),
    .resetn    (resetn),
    .load      (timerLoad),
    .loadValue (timerLoadValue),
    .dec       (timerDec),
    .zero      (timerZero)
  );

  assign {stop, right, left} = dirReg;
  assign shoot               = shootReg;
  assign start               = startReg;
  assign cmd_valid           = cmdValidReg;
  assign last_code           = lastCodeReg;
  assign reject_count        = rejectCountReg;

endmodule
